// File: rtl/irq_controller.sv
// irq_controller: latches N_CHANNELS requests, applies mask and global enable, arbitrates
// (fixed or round-robin) and runs the irq -> ack -> eoi handshake with the CPU.
module irq_controller #(
    parameter int unsigned           N_CHANNELS    = 4,
    parameter int unsigned           ADDR_WIDTH    = 16,
    parameter int unsigned           VECTOR_BASE   = 32'h0010,
    parameter int unsigned           VECTOR_STRIDE = 2,
    parameter logic [N_CHANNELS-1:0] EDGE_MASK     = '0,
    parameter bit                    ROUND_ROBIN   = 1'b0,
    parameter logic [N_CHANNELS-1:0] MASK_RESET    = '1,
    localparam int unsigned          ID_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_CHANNELS-1:0] irq_in_i,
    input  logic                  mask_we_i,
    input  logic [N_CHANNELS-1:0] mask_wdata_i,
    input  logic                  ie_set_i,
    input  logic                  ie_clear_i,
    input  logic                  irq_ack_i,
    input  logic                  irq_eoi_i,
    output logic                  irq_o,
    output logic [ADDR_WIDTH-1:0] irq_vector_o,
    output logic [ID_W-1:0]       irq_id_o,
    output logic                  in_service_o,
    output logic [N_CHANNELS-1:0] irq_clear_o,
    output logic [N_CHANNELS-1:0] pending_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [N_CHANNELS-1:0] irq_in_q, pending_q, pending_d, mask_q, mask_d;
    logic [N_CHANNELS-1:0] clr_q, clr_d, eoi_clr, eligible;
    logic                  ie_q, ie_d, irq_q, irq_d, in_service_q, in_service_d;
    logic [ID_W-1:0]       id_q, id_d, rr_q, rr_d, win, rr_idx;
    logic [ADDR_WIDTH-1:0] vec_q, vec_d, win_vec;
    logic                  eoi_fire, found;

    assign eoi_fire = (state_q == SERVICE) && irq_eoi_i;
    assign eoi_clr  = eoi_fire ? (N_CHANNELS'(1) << id_q) : '0;

    // A new edge in the same cycle as its own eoi must survive, so set wins over clear.
    assign pending_d = (EDGE_MASK & ((pending_q & ~eoi_clr) | (irq_in_i & ~irq_in_q)))
                     | (~EDGE_MASK & irq_in_i);
    assign mask_d    = mask_we_i ? mask_wdata_i : mask_q;
    assign ie_d      = ie_clear_i ? 1'b0 : (ie_set_i ? 1'b1 : ie_q);
    assign eligible  = ie_q ? (pending_q & mask_q) : '0;

    always_comb begin
        win    = '0;
        rr_idx = '0;
        found  = 1'b0;
        if (ROUND_ROBIN) begin
            for (int k = 1; k <= int'(N_CHANNELS); k++) begin
                rr_idx = ID_W'((int'(rr_q) + k) % int'(N_CHANNELS));
                if (!found && eligible[rr_idx]) begin
                    win   = rr_idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = int'(N_CHANNELS) - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    win = ID_W'(i);
                end
            end
        end
    end

    assign win_vec = ADDR_WIDTH'(VECTOR_BASE + 32'(win) * VECTOR_STRIDE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = REQUEST;
            REQUEST: begin
                if (~|eligible)     state_d = IDLE;
                else if (irq_ack_i) state_d = SERVICE;
            end
            SERVICE: if (irq_eoi_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Id/vector follow the arbiter until the ack freezes them.
    always_comb begin
        irq_d        = (state_d == REQUEST);
        in_service_d = (state_d == SERVICE);
        clr_d        = eoi_clr;
        id_d         = id_q;
        vec_d        = vec_q;
        rr_d         = rr_q;
        if (state_q != SERVICE && state_d == REQUEST) begin
            id_d  = win;
            vec_d = win_vec;
        end
        if (state_q == REQUEST && state_d == SERVICE) begin
            rr_d = id_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_in_q     <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            ie_q         <= 1'b0;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            clr_q        <= '0;
            id_q         <= '0;
            vec_q        <= ADDR_WIDTH'(VECTOR_BASE);
            rr_q         <= ID_W'(N_CHANNELS - 1);
        end else begin
            irq_in_q     <= irq_in_i;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            ie_q         <= ie_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            clr_q        <= clr_d;
            id_q         <= id_d;
            vec_q        <= vec_d;
            rr_q         <= rr_d;
        end
    end

    assign irq_o        = irq_q;
    assign irq_vector_o = vec_q;
    assign irq_id_o     = id_q;
    assign in_service_o = in_service_q;
    assign irq_clear_o  = clr_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: fixed-priority instance (ch0/ch2 edge) and round-robin instance.
module tb_irq_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  f_irq_in = '0, f_mask_wdata = '0, f_clr, f_pend;
    logic        f_mask_we = 0, f_ie_set = 0, f_ie_clear = 0, f_ack = 0, f_eoi = 0;
    logic        f_irq, f_insvc;
    logic [15:0] f_vec;
    logic [1:0]  f_id;

    logic [3:0]  r_irq_in = '0, r_mask_wdata = '0, r_clr, r_pend;
    logic        r_mask_we = 0, r_ie_set = 0, r_ie_clear = 0, r_ack = 0, r_eoi = 0;
    logic        r_irq, r_insvc;
    logic [15:0] r_vec;
    logic [1:0]  r_id;

    irq_controller #(.N_CHANNELS(4), .EDGE_MASK(4'b0101), .ROUND_ROBIN(1'b0)) dut_fix (
        .clk_i(clk), .rst_ni(rst_n), .irq_in_i(f_irq_in), .mask_we_i(f_mask_we),
        .mask_wdata_i(f_mask_wdata), .ie_set_i(f_ie_set), .ie_clear_i(f_ie_clear),
        .irq_ack_i(f_ack), .irq_eoi_i(f_eoi), .irq_o(f_irq), .irq_vector_o(f_vec),
        .irq_id_o(f_id), .in_service_o(f_insvc), .irq_clear_o(f_clr), .pending_o(f_pend));

    irq_controller #(.N_CHANNELS(4), .EDGE_MASK(4'b0000), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .irq_in_i(r_irq_in), .mask_we_i(r_mask_we),
        .mask_wdata_i(r_mask_wdata), .ie_set_i(r_ie_set), .ie_clear_i(r_ie_clear),
        .irq_ack_i(r_ack), .irq_eoi_i(r_eoi), .irq_o(r_irq), .irq_vector_o(r_vec),
        .irq_id_o(r_id), .in_service_o(r_insvc), .irq_clear_o(r_clr), .pending_o(r_pend));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0, n_fail = 0;

    function automatic void exp_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endfunction

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reset_vals();
        exp_push("rst_irq", 0);  exp_push("rst_insvc", 0); exp_push("rst_clr", 0);
        exp_push("rst_pend", 0); exp_push("rst_id", 0);    exp_push("rst_vec", 16'h0010);
    endtask

    task automatic chk_reset_vals();
        chk(f_irq); chk(f_insvc); chk(f_clr); chk(f_pend); chk(f_id); chk(f_vec);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        push_reset_vals();
        chk_reset_vals();
        rst_n = 1'b1;

        // Round-robin: all four level lines held high
        r_ie_set = 1; step(); r_ie_set = 0;
        r_irq_in = 4'hf;
        for (int rnd = 0; rnd < 5; rnd++) begin
            exp_push("rr_irq", 1);
            exp_push("rr_id", rnd % 4);
            for (int i = 0; i < 8; i++) begin
                if (r_irq) break;
                step();
            end
            chk(r_irq); chk(r_id);
            r_ack = 1; exp_push("rr_insvc", 1); step(); r_ack = 0;
            chk(r_insvc);
            r_eoi = 1; exp_push("rr_clr", 1 << (rnd % 4)); step(); r_eoi = 0;
            chk(r_clr);
        end
        r_irq_in = '0;

        // Edge on ch2: irq two cycles later
        f_ie_set = 1; step(); f_ie_set = 0;
        f_irq_in = 4'b0100;
        exp_push("t1_irq", 1); exp_push("t1_id", 2); exp_push("t1_vec", 16'h0014);
        exp_push("t1_pend", 4'b0100);
        step(); step();
        f_irq_in = '0;
        chk(f_irq); chk(f_id); chk(f_vec); chk(f_pend);
        f_ack = 1; exp_push("t1_insvc", 1); exp_push("t1_irq_ack", 0);
        step(); f_ack = 0;
        chk(f_insvc); chk(f_irq);
        f_eoi = 1; exp_push("t1_clr", 4'b0100); exp_push("t1_pend_eoi", 0); exp_push("t1_insvc_eoi", 0);
        step(); f_eoi = 0;
        chk(f_clr); chk(f_pend); chk(f_insvc);

        // Level 1010: ch1 first, device drops its line on eoi, then ch3
        f_irq_in = 4'b1010;
        exp_push("t2_irq", 1); exp_push("t2_id", 1); exp_push("t2_vec", 16'h0012);
        step(); step();
        chk(f_irq); chk(f_id); chk(f_vec);
        f_ack = 1; exp_push("t2_insvc", 1); exp_push("t2_id_frozen", 1);
        step(); f_ack = 0;
        chk(f_insvc); chk(f_id);
        f_eoi = 1; f_irq_in = 4'b1000; exp_push("t2_clr", 4'b0010);
        step(); f_eoi = 0;
        chk(f_clr);
        exp_push("t2_irq3", 1); exp_push("t2_id3", 3); exp_push("t2_vec3", 16'h0016);
        step();
        chk(f_irq); chk(f_id); chk(f_vec);
        f_ack = 1; step(); f_ack = 0;
        f_eoi = 1; f_irq_in = '0; exp_push("t2_clr3", 4'b1000);
        step(); f_eoi = 0;
        chk(f_clr);
        step();

        // Mask removes ch2 before ack: irq drops, no clear pulse, pending kept
        f_irq_in = 4'b0100;
        exp_push("t3_irq", 1); exp_push("t3_id", 2);
        step(); step(); f_irq_in = '0;
        chk(f_irq); chk(f_id);
        f_mask_we = 1; f_mask_wdata = 4'b1011;
        exp_push("t3_irq_masked", 0); exp_push("t3_insvc", 0); exp_push("t3_clr", 0); exp_push("t3_pend", 4'b0100);
        step(); f_mask_we = 0; step();
        chk(f_irq); chk(f_insvc); chk(f_clr); chk(f_pend);
        f_mask_we = 1; f_mask_wdata = 4'b1111;
        exp_push("t3_irq_unmask", 1); exp_push("t3_id_unmask", 2);
        step(); f_mask_we = 0; step();
        chk(f_irq); chk(f_id);
        f_ack = 1; step(); f_ack = 0;
        f_eoi = 1; exp_push("t3_clr_eoi", 4'b0100);
        step(); f_eoi = 0;
        chk(f_clr);

        // New ch0 edge coincident with its own eoi
        f_irq_in = 4'b0001;
        exp_push("t4_irq", 1); exp_push("t4_id", 0);
        step(); step(); f_irq_in = '0;
        chk(f_irq); chk(f_id);
        f_ack = 1; step(); f_ack = 0;
        f_irq_in = 4'b0001; f_eoi = 1;
        exp_push("t4_clr", 4'b0001); exp_push("t4_pend", 4'b0001);
        step(); f_eoi = 0;
        chk(f_clr); chk(f_pend);
        exp_push("t4_irq_again", 1); exp_push("t4_id_again", 0); exp_push("t4_vec_again", 16'h0010);
        step(); f_irq_in = '0;
        chk(f_irq); chk(f_id); chk(f_vec);

        // Reset during service, then spurious eoi/ack
        f_ack = 1; exp_push("t5_insvc", 1);
        step(); f_ack = 0;
        chk(f_insvc);
        #2 rst_n = 1'b0;
        #1;
        push_reset_vals();
        chk_reset_vals();
        step(); rst_n = 1'b1;
        f_eoi = 1; exp_push("t5_eoi_insvc", 0); exp_push("t5_eoi_clr", 0);
        step(); f_eoi = 0;
        chk(f_insvc); chk(f_clr);
        f_ack = 1; exp_push("t5_ack_irq", 0); exp_push("t5_ack_insvc", 0);
        step(); f_ack = 0;
        chk(f_irq); chk(f_insvc);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
